// File: rtl/rr_bus_arbiter.sv
// Registered round-robin arbiter granting one shared resource to one of N requesters.
// The owner holds the grant until done, request drop, or MAX_HOLD cycles elapse.
module rr_bus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IdW     = (N > 2) ? $clog2(N) : 1,
  localparam int unsigned CntW    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic           done_i,
  output logic [N-1:0]   grant_o,
  output logic [IdW-1:0] grant_id_o,
  output logic           busy_o,
  output logic           timeout_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [IdW-1:0]  last_q, last_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  logic            win_found;
  logic [IdW-1:0]  win_id;
  logic [IdW-1:0]  cand;
  logic            hold_limit;
  logic            owner_req;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdW'((int'(last_q) + int'(k)) % int'(N));
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign hold_limit = (hold_cnt_q == CntW'(MAX_HOLD - 1));
  assign owner_req  = req_i[grant_id_q];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (win_found) begin
          grant_d    = {{(N-1){1'b0}}, 1'b1} << win_id;
          grant_id_d = win_id;
          last_d     = win_id;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (done_i || !owner_req || hold_limit) begin
          grant_d    = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          state_d    = StIdle;
          // A voluntary release on the limit cycle is not a timeout.
          timeout_d  = !done_i && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= IdW'(N - 1);
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

  a_grant_onehot0: assert property (@(posedge clk_i) $onehot0(grant_q));
  a_busy_matches: assert property (@(posedge clk_i) busy_q == (|grant_q));
  a_timeout_idle: assert property (@(posedge clk_i) timeout_q |-> !busy_q);

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: an owner/length model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_rr_bus_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned MaxHold = 8;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       done = 1'b0;
  logic [3:0] req  = 4'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  rr_bus_arbiter #(
    .N        (N),
    .MAX_HOLD (MaxHold)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .done_i     (done),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  // owner = -1 means nobody holds the resource; len = cycles the grant has been high.
  typedef struct {
    int owner;
    int len;
    int last;
    int id;
    bit to;
  } mdl_t;

  mdl_t m_q = '{-1, 0, 3, 0, 1'b0};

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  int lit_seq = 0;
  int seen_seq = 0;
  string lit_name = "";
  logic [3:0] lit_grant = 4'b0;
  logic [1:0] lit_id = 2'b0;
  logic lit_busy = 1'b0;
  logic lit_to = 1'b0;

  logic [3:0] rot_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         rot_id [5] = '{0, 1, 2, 3, 0};

  function automatic mdl_t mstep(mdl_t s, logic [3:0] r, logic d, logic x);
    mdl_t n = s;
    n.to = 1'b0;
    if (x) begin
      n.owner = -1;
      n.len   = 0;
      n.last  = int'(N) - 1;
      n.id    = 0;
      return n;
    end
    if (s.owner < 0) begin
      for (int k = 1; k <= int'(N); k++) begin
        int i = (s.last + k) % int'(N);
        if (n.owner < 0 && r[i]) begin
          n.owner = i;
          n.last  = i;
          n.id    = i;
          n.len   = 1;
        end
      end
    end else if (d || !r[s.owner]) begin
      n.owner = -1;
    end else if (s.len == int'(MaxHold)) begin
      n.owner = -1;
      n.to    = 1'b1;
    end else begin
      n.len = s.len + 1;
    end
    return n;
  endfunction

  always @(posedge clk) m_q <= mstep(m_q, req, done, rst);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", 32'(grant), (m_q.owner < 0) ? 32'd0 : (32'd1 << m_q.owner));
      chk("grant_id", 32'(grant_id), 32'(m_q.id));
      chk("busy", 32'(busy), 32'(m_q.owner >= 0));
      chk("timeout", 32'(timeout), 32'(m_q.to));
      if (lit_seq != seen_seq) begin
        seen_seq <= lit_seq;
        chk({lit_name, ".grant"}, 32'(grant), 32'(lit_grant));
        chk({lit_name, ".grant_id"}, 32'(grant_id), 32'(lit_id));
        chk({lit_name, ".busy"}, 32'(busy), 32'(lit_busy));
        chk({lit_name, ".timeout"}, 32'(timeout), 32'(lit_to));
      end
    end
  end

  // Inputs are applied, then sampled on the next rising edge.
  task automatic cyc(input logic [3:0] r, input logic d, input logic x);
    req  = r;
    done = d;
    rst  = x;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [3:0] g, input logic [1:0] id,
                     input logic b, input logic t);
    lit_name  = nm;
    lit_grant = g;
    lit_id    = id;
    lit_busy  = b;
    lit_to    = t;
    lit_seq++;
  endtask

  initial begin
    cyc(4'b0000, 1'b0, 1'b1);
    chk_en = 1'b1;
    lit("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);

    cyc(4'b0100, 1'b0, 1'b0);
    lit("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    lit("single_done", 4'b0000, 2'd2, 1'b0, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);
    lit("idle_done_ignored", 4'b0000, 2'd2, 1'b0, 1'b0);

    cyc(4'b0000, 1'b0, 1'b1);
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 1'b0, 1'b0);
      lit("rot_grant", rot_g[g], 2'(rot_id[g]), 1'b1, 1'b0);
      cyc(4'b1111, 1'b0, 1'b0);
      cyc(4'b1111, 1'b0, 1'b0);
      cyc(4'b1111, 1'b1, 1'b0);
      lit("rot_release", 4'b0000, 2'(rot_id[g]), 1'b0, 1'b0);
    end

    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    lit("to_first", 4'b0010, 2'd1, 1'b1, 1'b0);
    repeat (7) cyc(4'b0010, 1'b0, 1'b0);
    lit("to_eighth", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    lit("to_pulse", 4'b0000, 2'd1, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    lit("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    repeat (7) cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0);
    lit("done_at_limit", 4'b0000, 2'd1, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0);
    lit("drop_owner", 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc(4'b1001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    lit("drop_release", 4'b0000, 2'd3, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    lit("drop_next", 4'b0001, 2'd0, 1'b1, 1'b0);

    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    lit("mid_owner", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b0110, 1'b0, 1'b0);
    cyc(4'b0110, 1'b0, 1'b1);
    lit("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(4'b0110, 1'b0, 1'b0);
    lit("mid_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Registered round-robin arbiter that shares one single-owner resource among `N` requesters. It drives the OR-reduced "any request" decision and grants the resource to exactly one requester at a time. The owner keeps the grant until it signals `done`, drops its request, or reaches a maximum hold time. It sits between the requesting blocks and the shared datapath; the datapath's enable is the one-hot `grant`.

## Interface
- `N`, 4: number of requesters; legal range 2..8.
- `MAX_HOLD`, 8: maximum consecutive cycles one grant may stay high; must be ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `req`  input  N  request vector; bit i high means requester i wants the resource.
- `done`  input  1  the current owner finishes; only meaningful while `busy` = 1.
- `grant`  output  N  one-hot grant, or all zero; registered.
- `grant_id`  output  max(1,$clog2(N))  index of the current or most recent owner; registered.
- `busy`  output  1  high while any grant bit is high; registered.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by `MAX_HOLD`; registered.

## Operation
- Two states: IDLE and GRANT. All outputs come from flops; there is no combinational path from inputs to outputs.
- Internal state:
  - `last` pointer, N-bit-indexed.
  - `hold_cnt`, width max(1,$clog2(MAX_HOLD)).
- Reset values:
  - state = IDLE
  - `grant` = 0, `grant_id` = 0, `busy` = 0, `timeout` = 0
  - `hold_cnt` = 0
  - `last` = N-1, so requester 0 has first priority.
- IDLE behaviour:
  - If `|req` = 0: stay in IDLE; outputs hold at 0, except `grant_id`, which keeps its last value.
  - If `|req` = 1: the winner is the first index i in the order last+1, last+2, …, last+N (mod N) with `req[i]` = 1.
  - On the next edge: `grant` <= one-hot(winner), `grant_id` <= winner, `last` <= winner, `busy` <= 1, `hold_cnt` <= 0, state <= GRANT.
- GRANT behaviour, evaluated each edge in this priority order:
  1. `done` = 1: release, with `timeout` <= 0.
  2. `req[grant_id]` = 0: release, with `timeout` <= 0. The owner abandoned its request.
  3. `hold_cnt` = MAX_HOLD-1: release, with `timeout` <= 1.
  4. Otherwise: `hold_cnt` <= `hold_cnt`+1 and `grant` is held.
- Release means: `grant` <= 0, `busy` <= 0, state <= IDLE, `grant_id` retained.
- `timeout` is forced to 0 on every edge that does not perform a timeout release. It is therefore exactly one cycle wide.
- `done` seen while in IDLE is ignored.
- Changes on `req` bits of non-owners during GRANT have no effect until the next IDLE cycle.

## Timing
- Grant latency: `req` first seen high at edge e in IDLE gives `grant` high after edge e, i.e. one cycle.
- Release latency: `done` high at edge e gives `grant` low after edge e.
- A mandatory dead cycle of at least one cycle with `grant` = 0 separates two owners. The earliest re-grant is at the following edge.
- Back-to-back handoff: continuous requests from two requesters produce the pattern grant A, ≥1 idle cycle, grant B.
- Maximum grant length is MAX_HOLD cycles (8 at default). `timeout` is high in the first idle cycle after the revoke.
- Simultaneous events:
  - `done` and hold limit on the same edge: normal release, `timeout` = 0.
  - `rst` together with anything: reset wins.
- Reset mid-GRANT: the edge with `rst` = 1 clears `grant`/`busy`/`timeout`, resets `last` to N-1, and returns to IDLE. Any pending request is then re-arbitrated from index 0.
- Fairness: with all N requests held high and no `done`, grants rotate 0,1,2,…,N-1,0. Each grant lasts MAX_HOLD cycles and is followed by one idle cycle.

## Test plan
- Reset then single request: `req`=4'b0100 from cycle 2 → `grant`=4'b0100 and `grant_id`=2 one cycle later. `done` pulsed 3 cycles later → `grant`=0 on the next cycle, `grant_id` stays 2.
- Contention rotation: `req`=4'b1111 held, `done` pulsed every 3rd grant cycle → grant sequence 0001,0010,0100,1000,0001, with one idle cycle between each.
- Timeout: `req`=4'b0010 held, `done`=0 → `grant`=4'b0010 for exactly 8 cycles, then `timeout`=1 for one cycle, then re-grant to 1 the following cycle.
- Done coincident with hold limit: `done`=1 on the 8th grant cycle → release with `timeout`=0.
- Request drop: owner 3 drops `req` mid-grant while `req[0]`=1 → `grant`=0 for one cycle, then `grant`=4'b0001.
- Reset mid-grant: owner 2 granted, `rst`=1 for one cycle with `req`=4'b0110 held → outputs are 0 after that edge, then the next grant goes to 1, since `last` was reset to 3.
